// File: rtl/serial_word_comparator_pkg.sv
// Shared definitions for the serial word comparator: FSM state encoding and
// the bit-pair width handled by the equality slice per clock.
package serial_word_comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned PAIR_W = 2;

endpackage

// File: rtl/serial_word_comparator_eq2_slice.sv
// Purely combinational 2-bit equality slice shared by the serial comparator.
module eq2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       eq
);

  assign eq = (x == y);

endmodule

// File: rtl/serial_word_comparator.sv
// Compares two WIDTH-bit words one bit-pair per clock, LSB pair first, stopping
// at the first mismatching pair. Reports equality and the first differing pair.
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDXW  = $clog2(WIDTH / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDXW-1:0]  mism_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH / PAIR_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDXW-1:0]  cnt;
  logic             pair_eq;

  eq2_slice u_slice (
    .x  (sa[PAIR_W-1:0]),
    .y  (sb[PAIR_W-1:0]),
    .eq (pair_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (!pair_eq || (cnt == LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge; results persist until
  // the next deciding compare, so a new start does not clear eq/mism_idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      eq       <= 1'b0;
      mism_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cnt <= '0;
          end
        end
        S_RUN: begin
          if (!pair_eq) begin
            eq       <= 1'b0;
            mism_idx <= cnt;
          end else if (cnt == LAST) begin
            eq       <= 1'b1;
            mism_idx <= '0;
          end else begin
            sa  <= sa >> PAIR_W;
            sb  <= sb >> PAIR_W;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_word_comparator.sv
// Randomised self-checking bench for serial_word_comparator (WIDTH=8) against
// a pair-by-pair reference model of the compare result and its latency.
module tb_serial_word_comparator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NPAIR = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic [1:0]       mism_idx;

  int checks = 0;
  int errors = 0;

  serial_word_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .mism_idx (mism_idx)
  );

  always #5 clk = ~clk;

  // Reference: scan pairs from the LSB; latency is (first mismatch + 1) or NPAIR.
  task automatic ref_compare(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                             output logic req, output int ridx, output int rlat);
    req  = 1'b1;
    ridx = 0;
    rlat = NPAIR;
    for (int i = 0; i < NPAIR; i++) begin
      if (((ra >> (2 * i)) & 3) != ((rb >> (2 * i)) & 3)) begin
        req  = 1'b0;
        ridx = i;
        rlat = i + 1;
        break;
      end
    end
  endtask

  // Issues one compare and observes 12 edges; optionally disturbs a/start in RUN.
  task automatic run_compare(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                             input bit disturb, output int lat, output int busy_cyc,
                             output int dones);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = -1;
    busy_cyc = busy ? 1 : 0;
    dones    = done ? 1 : 0;
    if (disturb) a = '0;
    for (int k = 1; k <= 12; k++) begin
      if (disturb && k == 2) start = 1'b1;
      if (disturb && k == 3) start = 1'b0;
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, eq, mism_idx} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b eq=%b idx=%0d, want all 0", busy, done, eq, mism_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, eq, mism_idx} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b eq=%b idx=%0d, want all 0", busy, done, eq, mism_idx);
    end
  endtask

  task automatic check_compare(input string name, input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb_v, input bit disturb);
    logic req;
    int ridx, rlat, lat, bc, dn;
    ref_compare(ta, tb_v, req, ridx, rlat);
    run_compare(ta, tb_v, disturb, lat, bc, dn);
    checks++;
    if (lat !== rlat) begin
      errors++;
      $display("FAIL %s_latency: a=%h b=%h got %0d edges, want %0d", name, ta, tb_v, lat, rlat);
    end
    checks++;
    if (bc !== rlat) begin
      errors++;
      $display("FAIL %s_busy: a=%h b=%h got %0d busy cycles, want %0d", name, ta, tb_v, bc, rlat);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL %s_done_count: a=%h b=%h got %0d pulses, want 1", name, ta, tb_v, dn);
    end
    checks++;
    if (eq !== req || int'(mism_idx) !== ridx) begin
      errors++;
      $display("FAIL %s_result: a=%h b=%h got eq=%b idx=%0d, want eq=%b idx=%0d",
               name, ta, tb_v, eq, mism_idx, req, ridx);
    end
  endtask

  task automatic test_match;
    check_compare("match_a5", 8'hA5, 8'hA5, 1'b0);
  endtask

  task automatic test_mismatch_first;
    check_compare("mism_p0", 8'hA5, 8'hA4, 1'b0);
  endtask

  task automatic test_mismatch_last;
    check_compare("mism_p3", 8'h25, 8'hA5, 1'b0);
  endtask

  task automatic test_ignore_inputs;
    check_compare("ignore_run", 8'hA5, 8'hA5, 1'b1);
  endtask

  task automatic test_result_hold;
    logic prev_eq;
    logic [1:0] prev_idx;
    check_compare("hold_setup", 8'h25, 8'hA5, 1'b0);
    prev_eq  = eq;
    prev_idx = mism_idx;
    @(negedge clk);
    a = 8'h11; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (eq !== prev_eq || mism_idx !== prev_idx || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_on_start: got eq=%b idx=%0d busy=%b, want eq=%b idx=%0d busy=1",
               eq, mism_idx, busy, prev_eq, prev_idx);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid_run;
    int dn;
    int lat, bc, dn2;
    logic req;
    int ridx, rlat;
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, eq, mism_idx} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b eq=%b idx=%0d, want all 0", busy, done, eq, mism_idx);
    end
    dn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d active cycles after abort, want 0", dn);
    end
    ref_compare(8'h3C, 8'h3C, req, ridx, rlat);
    run_compare(8'h3C, 8'h3C, 1'b0, lat, bc, dn2);
    checks++;
    if (lat !== rlat || eq !== req || int'(mism_idx) !== ridx || dn2 !== 1) begin
      errors++;
      $display("FAIL after_reset_3c: got lat=%0d eq=%b idx=%0d dones=%0d, want lat=%0d eq=%b idx=%0d dones=1",
               lat, eq, mism_idx, dn2, rlat, req, ridx);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb;
    for (int n = 0; n < 30; n++) begin
      ra = WIDTH'($urandom);
      rb = ra;
      if ($urandom_range(0, 3) != 0) rb[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) rb = WIDTH'($urandom);
      check_compare("random", ra, rb, 1'b0);
    end
  endtask

  // Held start re-accepts on every IDLE edge: one compare per (latency + 2) edges.
  task automatic test_back_to_back;
    logic [WIDTH-1:0] ra, rb;
    logic req;
    int ridx, rlat, dn, exp_dn;
    ra = WIDTH'($urandom);
    rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
    ref_compare(ra, rb, req, ridx, rlat);
    exp_dn = 0;
    for (int k = 1; k <= 17; k++) if (k % (rlat + 2) == rlat) exp_dn++;
    @(negedge clk);
    a = ra; b = rb; start = 1'b1;
    @(posedge clk);
    #1;
    dn = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    start = 1'b0;
    checks++;
    if (dn !== exp_dn) begin
      errors++;
      $display("FAIL back_to_back_count: a=%h b=%h got %0d done pulses, want %0d", ra, rb, dn, exp_dn);
    end
    checks++;
    if (eq !== req || int'(mism_idx) !== ridx) begin
      errors++;
      $display("FAIL back_to_back_result: got eq=%b idx=%0d, want eq=%b idx=%0d", eq, mism_idx, req, ridx);
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch_first();
    test_mismatch_last();
    test_ignore_inputs();
    test_result_hold();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
